ccff_chain_loader: RTL and testbench
====================================

# ccff_chain_loader

Configuration-chain driver that streams a bitstream into the `ccff_head` of a tile chain built from `*_mem` shift-register stages, such as connection-block and switch-block mux memories. It accepts bitstream words over a valid/ready handshake and serializes them MSB-first onto `ccff_head`. It produces a shift enable for the top-level prog-clock gate, and unpacks the bits emerging at the chain's `ccff_tail` into readback words. It sits between the bitstream source (JTAG/SPI bridge) and the first tile of each configuration chain.

## Interface
- `CHAIN_LEN`, 16, number of configuration flops in the attached chain (≥1). The default is 4 muxes × 4 SRAM bits.
- `WORD_W`, 8, bitstream and readback word width (≥2).
- `prog_clk`  in  1  configuration clock; single clock domain.
- `pReset`  in  1  reset, asynchronous, active-high.
- `start`  in  1  level; sampled only in IDLE; begins a load.
- `abort`  in  1  level; terminates the load at the next edge.
- `word_data`  in  WORD_W  bitstream word, MSB shifted first.
- `word_valid`  in  1  `word_data` valid.
- `word_ready`  out  1  loader accepts a word this cycle.
- `ccff_head`  out  1  serial data to the first chain stage; registered.
- `ccff_clk_en`  out  1  registered; the chain shifts at the edge ending every cycle where this is 1. The top level feeds it to the prog_clk ICG.
- `ccff_tail`  in  1  serial data from the last chain stage.
- `rd_data`  out  WORD_W  readback word (previous chain contents).
- `rd_valid`  out  1  one-cycle strobe; no backpressure.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse at completion.

## Operation
- States:
  - IDLE: on `start` → LOAD, with bit counter and packer cleared.
  - LOAD: shifts bits. After the last bit is shifted → DONE. On `abort` → IDLE.
  - DONE: one cycle, `done`=1, then → IDLE.
- Shift register `sreg[WORD_W]` with a pending-bit count.
  - In LOAD, each cycle with a pending bit sets `ccff_head`<=`sreg` MSB and `ccff_clk_en`<=1. It then shifts `sreg` left and increments `bits_sent`.
  - With no pending bit, it sets `ccff_clk_en`<=0 and holds `ccff_head`.
- `word_ready`=1 in LOAD when both hold:
  - the pending count is ≤1;
  - the bits still owed (`CHAIN_LEN - bits_sent - pending`) are >0.
- When the ready condition holds with pending=1, the new word loads on the same edge that the last pending bit issues. Back-to-back words therefore stream with no gap.
- Final word: only the top `CHAIN_LEN mod WORD_W` bits are issued (or all bits if the remainder is 0). The rest are discarded, and no further words are accepted.
- Bit order: the first bit issued ends at the flop nearest `ccff_tail`. The first bit out on a later load is the first bit in on this load.
- Readback: at every edge where registered `ccff_clk_en`=1, `ccff_tail` is shifted into the packer's LSB.
  - After `WORD_W` samples, `rd_data` is presented with `rd_valid` for one cycle.
  - At the final sample, a partial word is left-justified and zero-padded, and presented in the same cycle `done`=1.
- `start` outside IDLE, and `word_valid` outside LOAD, are ignored.
- `abort`: `ccff_clk_en`<=0 at the next edge, any partial readback is dropped, and `done` is not asserted. Chain contents are then undefined.
- Counters are `$clog2(CHAIN_LEN+1)` bits wide, with no wrap; `bits_sent` saturates at `CHAIN_LEN`.

## Timing
- Reset values: `word_ready`=0, `ccff_head`=0, `ccff_clk_en`=0, `rd_data`=0, `rd_valid`=0, `busy`=0, `done`=0, state=IDLE.
- Word accepted at edge k:
  - its MSB is on `ccff_head` with `ccff_clk_en`=1 in the cycle after edge k+1;
  - the chain captures it at edge k+2.
- `done` asserts in the cycle after the edge that captured the final bit.
- Exactly `CHAIN_LEN` `ccff_clk_en` cycles occur per completed load.
- `pReset` mid-load has the same effect as `abort`, plus every output goes to its reset value immediately (asynchronous).

## Structure
- Package `ccff_loader_pkg`: the state enum (`CCFF_IDLE`, `CCFF_LOAD`, `CCFF_DONE`) and a `ccff_cnt_w(CHAIN_LEN)` function.
- One sub-module: `ccff_readback_packer`, which holds the tail sampling, word packing, partial flush and `rd_valid` strobe.

## Test plan
The bench uses a behavioural chain: 16 flops clocked on `prog_clk & ccff_clk_en`, with flop[15] driving `ccff_tail`. The chain is pre-zeroed.
- Reset: hold `pReset` with random inputs → all outputs are 0 and `busy`=0. Release with `start`=0 → the block stays idle.
- `start`, then words 0xA5 and 0xC3 back-to-back → 16 contiguous `ccff_clk_en` cycles. Chain flops 15..0 = 1010_0101_1100_0011. `rd_data` 0x00, then 0x00. `done` is 1 for one cycle.
- Reload with 0xFF, 0x00 → `rd_data` 0xA5, then 0xC3. The chain holds 0xFF00.
- `word_valid` low for 3 cycles between words → `ccff_clk_en` is low for exactly 3 cycles. The final chain content equals the no-stall case.
- `CHAIN_LEN`=12, words 0xAB and 0xCD → 12 enable cycles; the chain holds 0xABC. `word_ready` is never asserted after the second word. Reloading returns `rd_data` 0xAB, then 0xC0.
- `abort` after 5 bits, then `pReset` pulsed during a later load → `ccff_clk_en` is 0 at the next edge (or immediately on reset). There is no `done` and no partial `rd_valid`. The next `start`/load completes normally.

Source files
------------

// File: rtl/ccff_loader_pkg.sv
// Shared types and helpers for the configuration-chain loader.
// Holds the loader FSM encoding and the counter-width helper.
// Imported by ccff_chain_loader and ccff_readback_packer.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    CCFF_IDLE = 2'd0,
    CCFF_LOAD = 2'd1,
    CCFF_DONE = 2'd2
  } ccff_state_e;

  // Width that can hold every value 0..chain_len inclusive.
  function automatic int ccff_cnt_w(input int chain_len);
    return $clog2(chain_len + 1);
  endfunction

endpackage

// File: rtl/ccff_readback_packer.sv
// Packs bits leaving the chain tail into readback words; flushes a final partial word.
// Latency: rd_valid/rd_data appear the cycle after the edge taking the word's last sample.
// No backpressure: rd_valid is a one-cycle strobe the consumer must take.
// Ports: prog_clk/pReset clock and async reset; clear drops any partial word and restarts
// the sample count; sample_en marks edges where the chain shifts; ccff_tail is the chain
// output; rd_data/rd_valid carry the packed readback word.
module ccff_readback_packer
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 16,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              clear,
  input  logic              sample_en,
  input  logic              ccff_tail,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid
);

  localparam int CW  = ccff_cnt_w(CHAIN_LEN);
  localparam int WCW = $clog2(WORD_W);
  localparam logic [CW-1:0]  TOTAL_LAST = CW'(CHAIN_LEN - 1);
  localparam logic [CW-1:0]  TOTAL_MAX  = CW'(CHAIN_LEN);
  localparam logic [WCW-1:0] WORD_LAST  = WCW'(WORD_W - 1);

  logic [WORD_W-1:0] acc_q, acc_d;
  logic [WCW-1:0]    wcnt_q, wcnt_d;
  logic [CW-1:0]     total_q, total_d;
  logic [WORD_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic [WORD_W-1:0] acc_shift;

  assign acc_shift = {acc_q[WORD_W-2:0], ccff_tail};

  always_comb begin
    acc_d      = acc_q;
    wcnt_d     = wcnt_q;
    total_d    = total_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    if (clear) begin
      acc_d   = '0;
      wcnt_d  = '0;
      total_d = '0;
    end else if (sample_en) begin
      if (total_q != TOTAL_MAX) begin
        total_d = total_q + CW'(1);
      end
      if (wcnt_q == WORD_LAST) begin
        rd_data_d  = acc_shift;
        rd_valid_d = 1'b1;
        acc_d      = '0;
        wcnt_d     = '0;
      end else if (total_q == TOTAL_LAST) begin
        // Final sample of the chain: left-justify the wcnt_q+1 collected bits.
        rd_data_d  = acc_shift << (WORD_LAST - wcnt_q);
        rd_valid_d = 1'b1;
        acc_d      = '0;
        wcnt_d     = '0;
      end else begin
        acc_d  = acc_shift;
        wcnt_d = wcnt_q + WCW'(1);
      end
    end
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      acc_q      <= '0;
      wcnt_q     <= '0;
      total_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      wcnt_q     <= wcnt_d;
      total_q    <= total_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: rtl/ccff_chain_loader.sv
// Streams bitstream words MSB-first into a ccff shift chain and unpacks the displaced contents.
// Latency: word accepted at edge k drives ccff_head/ccff_clk_en from edge k+1; chain captures at k+2.
// Backpressure: word_ready only while at most one bit is pending and chain bits are still owed.
// Ports: prog_clk/pReset clock and async reset; start/abort load control; word_data/valid/ready
// bitstream input; ccff_head/ccff_clk_en chain drive; ccff_tail chain return; rd_data/rd_valid
// readback words; busy (not idle) and done (one-cycle completion pulse).
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 16,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              ccff_clk_en,
  input  logic              ccff_tail,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done
);

  localparam int CW = ccff_cnt_w(CHAIN_LEN);
  localparam logic [CW-1:0] CHAIN_LEN_C = CW'(CHAIN_LEN);

  ccff_state_e       state_q, state_d;
  logic [CW-1:0]     bits_sent_q, bits_sent_d;
  logic [CW-1:0]     pending_q, pending_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic              ccff_head_q, ccff_head_d;
  logic              ccff_clk_en_q, ccff_clk_en_d;
  logic [CW-1:0]     owed;
  logic [CW-1:0]     load_cnt;
  logic              accept;
  logic              pk_clear;

  // bits_sent + pending never exceeds CHAIN_LEN, so this cannot underflow.
  assign owed       = CHAIN_LEN_C - bits_sent_q - pending_q;
  assign word_ready = (state_q == CCFF_LOAD) && (pending_q <= CW'(1)) && (owed != '0);
  assign accept     = word_valid && word_ready;
  // The last word only contributes the bits the chain still needs; its low bits are dropped.
  assign load_cnt   = (32'(owed) >= WORD_W) ? CW'(WORD_W) : owed;

  always_comb begin
    state_d       = state_q;
    bits_sent_d   = bits_sent_q;
    pending_d     = pending_q;
    sreg_d        = sreg_q;
    ccff_head_d   = ccff_head_q;
    ccff_clk_en_d = ccff_clk_en_q;
    pk_clear      = 1'b0;
    case (state_q)
      CCFF_IDLE: begin
        ccff_clk_en_d = 1'b0;
        if (start) begin
          state_d     = CCFF_LOAD;
          bits_sent_d = '0;
          pending_d   = '0;
          pk_clear    = 1'b1;
        end
      end
      CCFF_LOAD: begin
        if (abort) begin
          state_d       = CCFF_IDLE;
          ccff_clk_en_d = 1'b0;
          pending_d     = '0;
          pk_clear      = 1'b1;
        end else begin
          if (pending_q != '0) begin
            ccff_head_d   = sreg_q[WORD_W-1];
            ccff_clk_en_d = 1'b1;
            sreg_d        = {sreg_q[WORD_W-2:0], 1'b0};
            pending_d     = pending_q - CW'(1);
            if (bits_sent_q != CHAIN_LEN_C) begin
              bits_sent_d = bits_sent_q + CW'(1);
            end
          end else begin
            ccff_clk_en_d = 1'b0;
            // Reached one edge after the last bit was issued, i.e. as the chain captures it.
            if (bits_sent_q == CHAIN_LEN_C) begin
              state_d = CCFF_DONE;
            end
          end
          // A word taken while the last pending bit issues overwrites sreg on the same
          // edge, so consecutive words stream without a gap.
          if (accept) begin
            sreg_d    = word_data;
            pending_d = load_cnt;
          end
        end
      end
      CCFF_DONE: begin
        ccff_clk_en_d = 1'b0;
        state_d       = CCFF_IDLE;
      end
      default: begin
        ccff_clk_en_d = 1'b0;
        state_d       = CCFF_IDLE;
      end
    endcase
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state_q       <= CCFF_IDLE;
      bits_sent_q   <= '0;
      pending_q     <= '0;
      sreg_q        <= '0;
      ccff_head_q   <= 1'b0;
      ccff_clk_en_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bits_sent_q   <= bits_sent_d;
      pending_q     <= pending_d;
      sreg_q        <= sreg_d;
      ccff_head_q   <= ccff_head_d;
      ccff_clk_en_q <= ccff_clk_en_d;
    end
  end

  // The chain shifts on exactly the edges where the registered enable is high,
  // so the same signal tells the packer when ccff_tail carries a new bit.
  ccff_readback_packer #(
    .CHAIN_LEN (CHAIN_LEN),
    .WORD_W    (WORD_W)
  ) u_packer (
    .prog_clk  (prog_clk),
    .pReset    (pReset),
    .clear     (pk_clear),
    .sample_en (ccff_clk_en_q),
    .ccff_tail (ccff_tail),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid)
  );

  assign ccff_head   = ccff_head_q;
  assign ccff_clk_en = ccff_clk_en_q;
  assign busy        = (state_q != CCFF_IDLE);
  assign done        = (state_q == CCFF_DONE);

endmodule

// File: tb/tb_ccff_chain_loader.sv
module tb_ccff_chain_loader;

  logic prog_clk = 1'b0;
  logic pReset;

  // Index 0: 16-flop chain, index 1: 12-flop chain.
  logic [1:0]      start_i, abort_i, wvld_i;
  logic [1:0][7:0] wdat_i;
  logic [1:0]      rdy_o, head_o, en_o, rdv_o, busy_o, done_o;
  logic [1:0][7:0] rdd_o;

  logic [15:0] chain16 = '0;
  logic [11:0] chain12 = '0;
  logic        tail16, tail12;

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];

  int en_total[2], en_gaps[2], pend_low[2], done_cnt[2], done_base[2];
  bit seen_en[2], prev_en[2], prev_done[2];

  always #5 prog_clk = ~prog_clk;

  ccff_chain_loader #(.CHAIN_LEN(16), .WORD_W(8)) dut16 (
    .prog_clk(prog_clk), .pReset(pReset), .start(start_i[0]), .abort(abort_i[0]),
    .word_data(wdat_i[0]), .word_valid(wvld_i[0]), .word_ready(rdy_o[0]),
    .ccff_head(head_o[0]), .ccff_clk_en(en_o[0]), .ccff_tail(tail16),
    .rd_data(rdd_o[0]), .rd_valid(rdv_o[0]), .busy(busy_o[0]), .done(done_o[0])
  );

  ccff_chain_loader #(.CHAIN_LEN(12), .WORD_W(8)) dut12 (
    .prog_clk(prog_clk), .pReset(pReset), .start(start_i[1]), .abort(abort_i[1]),
    .word_data(wdat_i[1]), .word_valid(wvld_i[1]), .word_ready(rdy_o[1]),
    .ccff_head(head_o[1]), .ccff_clk_en(en_o[1]), .ccff_tail(tail12),
    .rd_data(rdd_o[1]), .rd_valid(rdv_o[1]), .busy(busy_o[1]), .done(done_o[1])
  );

  // Behavioural chains: shift on edges where the registered enable is high.
  always @(posedge prog_clk) if (en_o[0]) chain16 <= {chain16[14:0], head_o[0]};
  always @(posedge prog_clk) if (en_o[1]) chain12 <= {chain12[10:0], head_o[1]};
  assign tail16 = chain16[15];
  assign tail12 = chain12[11];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  function automatic void push_exp(input int s, input logic [7:0] v);
    if (s == 0) exp_q0.push_back(v);
    else        exp_q1.push_back(v);
  endfunction

  function automatic int exp_size(input int s);
    return (s == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  // Monitor: scoreboard for readback, done pulse shape and enable bookkeeping.
  initial begin
    logic [7:0] ev;
    int qn;
    forever begin
      @(negedge prog_clk);
      for (int s = 0; s < 2; s++) begin
        if (rdv_o[s]) begin
          qn = exp_size(s);
          chk($sformatf("rd_expected[%0d]", s), 32'(qn > 0), 1);
          if (qn > 0) begin
            if (s == 0) ev = exp_q0.pop_front();
            else        ev = exp_q1.pop_front();
            chk($sformatf("rd_data[%0d]", s), 32'(rdd_o[s]), 32'(ev));
          end
        end
        if (done_o[s]) begin
          done_cnt[s]++;
          chk($sformatf("done_one_cycle[%0d]", s), 32'(prev_done[s]), 0);
          chk($sformatf("done_with_rd[%0d]", s), 32'(rdv_o[s]), 1);
          chk($sformatf("done_after_last_en[%0d]", s), {30'd0, prev_en[s], en_o[s]}, 2);
        end
        if (en_o[s]) begin
          if (seen_en[s]) en_gaps[s] += pend_low[s];
          pend_low[s] = 0;
          seen_en[s]  = 1'b1;
          en_total[s]++;
        end else if (seen_en[s]) begin
          pend_low[s]++;
        end
        prev_done[s] = done_o[s];
        prev_en[s]   = en_o[s];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic begin_load(input int s);
    en_total[s] = 0; en_gaps[s] = 0; pend_low[s] = 0; seen_en[s] = 1'b0;
    done_base[s] = done_cnt[s];
    start_i[s] = 1'b1;
    @(posedge prog_clk); #1;
    start_i[s] = 1'b0;
  endtask

  task automatic send(input int s, input logic [7:0] d);
    bit acc = 1'b0;
    int t = 0;
    wdat_i[s] = d;
    wvld_i[s] = 1'b1;
    while (!acc && t < 200) begin
      @(negedge prog_clk);
      acc = rdy_o[s];
      @(posedge prog_clk); #1;
      t++;
    end
    wvld_i[s] = 1'b0;
    chk($sformatf("send_accepted[%0d]", s), 32'(acc), 1);
  endtask

  task automatic wait_idle(input int s);
    int t = 0;
    while (busy_o[s] && t < 200) begin
      @(posedge prog_clk); #1;
      t++;
    end
    chk($sformatf("idle_reached[%0d]", s), 32'(busy_o[s]), 0);
    repeat (2) @(posedge prog_clk);
    #1;
  endtask

  task automatic finish_load(input int s, input int x_en, input int x_gaps, input int x_done);
    chk($sformatf("en_cycles[%0d]", s), en_total[s], x_en);
    chk($sformatf("en_gaps[%0d]", s), en_gaps[s], x_gaps);
    chk($sformatf("done_count[%0d]", s), done_cnt[s] - done_base[s], x_done);
    chk($sformatf("rd_drained[%0d]", s), exp_size(s), 0);
  endtask

  initial begin
    int t, n, r;
    pReset  = 1'b1;
    start_i = '0; abort_i = '0; wvld_i = '0; wdat_i = '0;

    // Reset held with random inputs: every output stays at its reset value.
    repeat (3) begin
      @(posedge prog_clk); #1;
      for (int s = 0; s < 2; s++) begin
        start_i[s] = 1'($urandom_range(0, 1));
        abort_i[s] = 1'($urandom_range(0, 1));
        wvld_i[s]  = 1'($urandom_range(0, 1));
        wdat_i[s]  = 8'($urandom);
      end
      @(negedge prog_clk);
      for (int s = 0; s < 2; s++)
        chk($sformatf("reset_outputs[%0d]", s),
            {18'd0, rdy_o[s], head_o[s], en_o[s], rdd_o[s], rdv_o[s], busy_o[s], done_o[s]}, 0);
    end
    @(posedge prog_clk); #1;
    start_i = '0; abort_i = '0; wvld_i = '0; wdat_i = '0;
    pReset  = 1'b0;
    repeat (4) @(posedge prog_clk);
    #1;
    for (int s = 0; s < 2; s++)
      chk($sformatf("idle_after_reset[%0d]", s), {30'd0, busy_o[s], en_o[s]}, 0);

    // First load into a zeroed chain.
    push_exp(0, 8'h00); push_exp(0, 8'h00);
    begin_load(0);
    send(0, 8'hA5); send(0, 8'hC3);
    wait_idle(0);
    finish_load(0, 16, 0, 1);
    chk("chain16_a5c3", 32'(chain16), 32'hA5C3);

    // Reload: previous contents come back first-in first-out.
    push_exp(0, 8'hA5); push_exp(0, 8'hC3);
    begin_load(0);
    send(0, 8'hFF); send(0, 8'h00);
    wait_idle(0);
    finish_load(0, 16, 0, 1);
    chk("chain16_ff00", 32'(chain16), 32'hFF00);

    // Source stalls three ready cycles between words.
    push_exp(0, 8'hFF); push_exp(0, 8'h00);
    begin_load(0);
    send(0, 8'h12);
    t = 0;
    while (!rdy_o[0] && t < 50) begin
      @(negedge prog_clk);
      t++;
    end
    chk("ready_for_second", 32'(rdy_o[0]), 1);
    repeat (3) @(posedge prog_clk);
    #1;
    send(0, 8'h34);
    wait_idle(0);
    finish_load(0, 16, 3, 1);
    chk("chain16_1234", 32'(chain16), 32'h1234);

    // Abort after five bits: enable drops at the next edge, no done, no partial readback.
    begin_load(0);
    send(0, 8'h3C);
    n = 0; t = 0;
    while (n < 5 && t < 100) begin
      @(negedge prog_clk);
      if (en_o[0]) n++;
      t++;
    end
    abort_i[0] = 1'b1;
    @(posedge prog_clk); #1;
    chk("abort_en_low", 32'(en_o[0]), 0);
    chk("abort_idle", 32'(busy_o[0]), 0);
    abort_i[0] = 1'b0;
    repeat (12) @(posedge prog_clk);
    #1;
    finish_load(0, 5, 0, 0);

    // Reset pulsed mid-load: outputs drop immediately.
    begin_load(0);
    send(0, 8'h11);
    n = 0; t = 0;
    while (n < 3 && t < 100) begin
      @(negedge prog_clk);
      if (en_o[0]) n++;
      t++;
    end
    #1 pReset = 1'b1;
    #1;
    chk("reset_mid_load", {28'd0, en_o[0], busy_o[0], rdy_o[0], head_o[0]}, 0);
    @(posedge prog_clk); #1;
    pReset = 1'b0;
    repeat (12) @(posedge prog_clk);
    #1;
    chk("reset_no_done", done_cnt[0] - done_base[0], 0);
    chk("reset_no_rd", exp_size(0), 0);

    // Next load completes normally; readback is whatever the chain held.
    push_exp(0, chain16[15:8]); push_exp(0, chain16[7:0]);
    begin_load(0);
    send(0, 8'h5A); send(0, 8'h96);
    wait_idle(0);
    finish_load(0, 16, 0, 1);
    chk("chain16_5a96", 32'(chain16), 32'h5A96);

    // 12-flop chain: second word is truncated to its top four bits.
    push_exp(1, 8'h00); push_exp(1, 8'h00);
    begin_load(1);
    send(1, 8'hAB); send(1, 8'hCD);
    r = 0; t = 0;
    while (busy_o[1] && t < 100) begin
      if (rdy_o[1]) r++;
      @(posedge prog_clk); #1;
      t++;
    end
    chk("ready_after_last_word", r, 0);
    wait_idle(1);
    finish_load(1, 12, 0, 1);
    chk("chain12_abc", 32'(chain12), 32'hABC);

    // Reload of the 12-flop chain returns a left-justified partial word.
    push_exp(1, 8'hAB); push_exp(1, 8'hC0);
    begin_load(1);
    send(1, 8'h12); send(1, 8'h34);
    wait_idle(1);
    finish_load(1, 12, 0, 1);
    chk("chain12_123", 32'(chain12), 32'h123);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
